// File: rtl/riscv_pkg.sv
// Shared definitions for the writeback stage: widths, load funct3 codes and FSM states.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Load width/sign encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    DONE      = 2'd2
  } wb_state_t;

  // True for the funct3 codes that do not name any load (011, 110, 111)
  function automatic logic is_illegal_load_f3(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load data extraction: selects the byte/half/word lane addressed by
// the low address bits and sign- or zero-extends it. Also flags misaligned accesses
// and funct3 codes that are not loads; the fault does not depend on the data word.
module load_extract
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] value,
  output logic            fault
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = mem_rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = mem_rdata[16*gi +: 16];
    end
  endgenerate

  assign sel_byte = byte_lane[offset];
  assign sel_half = half_lane[offset[1]];

  // Extend the selected lane and classify the access
  always_comb begin
    value = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  value = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LBU: value = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LH: begin
        value = {{(XLEN-16){sel_half[15]}}, sel_half};
        fault = offset[0];
      end
      F3_LHU: begin
        value = {{(XLEN-16){1'b0}}, sel_half};
        fault = offset[0];
      end
      F3_LW: begin
        value = mem_rdata;
        fault = (offset != 2'b00);
      end
      default: fault = is_illegal_load_f3(funct3);
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: picks ALU result, load data or PC+4 and drives the register
// file write port. Loads wait for the memory response; faulty loads retire at once.
// All outputs except in_ready are registered, so no in_* signal reaches the write port
// combinationally.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int XLEN_P       = XLEN,
  parameter int REG_ADDR_W_P = REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_ADDR_W_P-1:0] in_rd,
  input  logic                    in_regWrite,
  input  logic                    in_load,
  input  logic                    in_JAL,
  input  logic                    in_JALR,
  input  logic [2:0]              in_funct3,
  input  logic [XLEN_P-1:0]       in_aluResult,
  input  logic [XLEN_P-1:0]       in_incrementedPC,
  input  logic                    mem_rvalid,
  input  logic [XLEN_P-1:0]       mem_rdata,
  output logic                    write,
  output logic [REG_ADDR_W_P-1:0] rd,
  output logic [XLEN_P-1:0]       writeData,
  output logic                    retire,
  output logic                    load_fault
);

  wb_state_t               state_reg, state_next;
  logic                    write_reg, write_next;
  logic [REG_ADDR_W_P-1:0] rd_reg, rd_next;
  logic [XLEN_P-1:0]       wdata_reg, wdata_next;
  logic                    retire_reg, retire_next;
  logic                    fault_reg, fault_next;

  // Pending load context captured at acceptance
  logic [REG_ADDR_W_P-1:0] pend_rd_reg, pend_rd_next;
  logic                    pend_wr_reg, pend_wr_next;
  logic [2:0]              pend_f3_reg, pend_f3_next;
  logic [1:0]              pend_off_reg, pend_off_next;

  logic                    accept;
  logic [2:0]              ext_f3;
  logic [1:0]              ext_off;
  logic [XLEN_P-1:0]       ext_value;
  logic                    ext_fault;

  assign in_ready = (state_reg != WAIT_LOAD);
  assign accept   = in_valid && in_ready;

  // While waiting, extract with the latched context; otherwise classify the incoming load
  assign ext_f3  = (state_reg == WAIT_LOAD) ? pend_f3_reg  : in_funct3;
  assign ext_off = (state_reg == WAIT_LOAD) ? pend_off_reg : in_aluResult[1:0];

  load_extract u_load_extract (
    .mem_rdata (mem_rdata),
    .funct3    (ext_f3),
    .offset    (ext_off),
    .value     (ext_value),
    .fault     (ext_fault)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      write_reg    <= 1'b0;
      rd_reg       <= '0;
      wdata_reg    <= '0;
      retire_reg   <= 1'b0;
      fault_reg    <= 1'b0;
      pend_rd_reg  <= '0;
      pend_wr_reg  <= 1'b0;
      pend_f3_reg  <= '0;
      pend_off_reg <= '0;
    end else begin
      state_reg    <= state_next;
      write_reg    <= write_next;
      rd_reg       <= rd_next;
      wdata_reg    <= wdata_next;
      retire_reg   <= retire_next;
      fault_reg    <= fault_next;
      pend_rd_reg  <= pend_rd_next;
      pend_wr_reg  <= pend_wr_next;
      pend_f3_reg  <= pend_f3_next;
      pend_off_reg <= pend_off_next;
    end
  end

  // Next-state and next-output selection; pulses default low, rd/data hold
  always_comb begin
    state_next    = state_reg;
    write_next    = 1'b0;
    retire_next   = 1'b0;
    fault_next    = 1'b0;
    rd_next       = rd_reg;
    wdata_next    = wdata_reg;
    pend_rd_next  = pend_rd_reg;
    pend_wr_next  = pend_wr_reg;
    pend_f3_next  = pend_f3_reg;
    pend_off_next = pend_off_reg;

    case (state_reg)
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          write_next  = pend_wr_reg && (pend_rd_reg != '0);
          rd_next     = pend_rd_reg;
          wdata_next  = ext_value;
          retire_next = 1'b1;
          state_next  = DONE;
        end
      end
      default: begin
        // IDLE and DONE behave identically on acceptance
        if (accept) begin
          if (in_load) begin
            if (ext_fault) begin
              // Faulty load retires immediately without touching the register file
              rd_next     = in_rd;
              retire_next = 1'b1;
              fault_next  = 1'b1;
              state_next  = DONE;
            end else begin
              pend_rd_next  = in_rd;
              pend_wr_next  = in_regWrite;
              pend_f3_next  = in_funct3;
              pend_off_next = in_aluResult[1:0];
              state_next    = WAIT_LOAD;
            end
          end else begin
            write_next  = in_regWrite && (in_rd != '0);
            rd_next     = in_rd;
            wdata_next  = (in_JAL || in_JALR) ? in_incrementedPC : in_aluResult;
            retire_next = 1'b1;
            state_next  = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  assign write      = write_reg;
  assign rd         = rd_reg;
  assign writeData  = wdata_reg;
  assign retire     = retire_reg;
  assign load_fault = fault_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage with hand-computed expected values.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regWrite;
  logic        in_load;
  logic        in_JAL;
  logic        in_JALR;
  logic [2:0]  in_funct3;
  logic [31:0] in_aluResult;
  logic [31:0] in_incrementedPC;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        write;
  logic [4:0]  rd;
  logic [31:0] writeData;
  logic        retire;
  logic        load_fault;

  int checks   = 0;
  int failures = 0;

  writeback_stage dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_rd            (in_rd),
    .in_regWrite      (in_regWrite),
    .in_load          (in_load),
    .in_JAL           (in_JAL),
    .in_JALR          (in_JALR),
    .in_funct3        (in_funct3),
    .in_aluResult     (in_aluResult),
    .in_incrementedPC (in_incrementedPC),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .write            (write),
    .rd               (rd),
    .writeData        (writeData),
    .retire           (retire),
    .load_fault       (load_fault)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] r, input logic wr, input logic ld,
                          input logic jal, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] pc);
    in_valid         = 1'b1;
    in_rd            = r;
    in_regWrite      = wr;
    in_load          = ld;
    in_JAL           = jal;
    in_JALR          = 1'b0;
    in_funct3        = f3;
    in_aluResult     = alu;
    in_incrementedPC = pc;
  endtask

  // Accept a load (with a stray mem_rvalid at acceptance that must be ignored),
  // wait the given cycles, then deliver the response and check the write.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [4:0] r, input int waits,
                          input logic [31:0] data, input logic [31:0] exp);
    drive_op(r, 1'b1, 1'b1, 1'b0, f3, alu, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_DEAD;
    tick();
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check_value({tag, "_ready_wait"}, {31'b0, in_ready}, 32'd0);
      check_value({tag, "_write_wait"}, {31'b0, write}, 32'd0);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
    $display("load %s rd=%0d data=0x%08h write=%0b writeData=0x%08h", tag, r, data, write, writeData);
    check_value({tag, "_write"}, {31'b0, write}, 32'd1);
    check_value({tag, "_retire"}, {31'b0, retire}, 32'd1);
    check_value({tag, "_rd"}, {27'b0, rd}, {27'b0, r});
    check_value({tag, "_data"}, writeData, exp);
    check_value({tag, "_ready_after"}, {31'b0, in_ready}, 32'd1);
    tick();
    check_value({tag, "_write_clear"}, {31'b0, write}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    drive_op(5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h4);

    // Reset held with a valid instruction presented
    tick();
    tick();
    $display("reset held: write=%0b retire=%0b rd=%0d writeData=0x%08h", write, retire, rd, writeData);
    check_value("rst_write", {31'b0, write}, 32'd0);
    check_value("rst_retire", {31'b0, retire}, 32'd0);
    check_value("rst_fault", {31'b0, load_fault}, 32'd0);
    check_value("rst_rd", {27'b0, rd}, 32'd0);
    check_value("rst_data", writeData, 32'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    check_value("rel_ready", {31'b0, in_ready}, 32'd1);
    check_value("rel_write", {31'b0, write}, 32'd0);

    // ALU op then back-to-back JAL
    drive_op(5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h0000_0100);
    tick();
    $display("alu rd=%0d write=%0b writeData=0x%08h", rd, write, writeData);
    check_value("alu_write", {31'b0, write}, 32'd1);
    check_value("alu_rd", {27'b0, rd}, 32'd5);
    check_value("alu_data", writeData, 32'h10);
    check_value("alu_retire", {31'b0, retire}, 32'd1);
    drive_op(5'd1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0FFC, 32'h0000_0008);
    tick();
    in_valid = 1'b0;
    $display("jal rd=%0d write=%0b writeData=0x%08h", rd, write, writeData);
    check_value("jal_write", {31'b0, write}, 32'd1);
    check_value("jal_rd", {27'b0, rd}, 32'd1);
    check_value("jal_data", writeData, 32'h8);
    check_value("jal_retire", {31'b0, retire}, 32'd1);
    tick();
    check_value("idle_write", {31'b0, write}, 32'd0);
    check_value("idle_retire", {31'b0, retire}, 32'd0);
    check_value("idle_hold_data", writeData, 32'h8);

    // JALR also selects PC+4
    drive_op(5'd2, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0ABC, 32'h0000_0044);
    in_JALR = 1'b1;
    tick();
    in_valid = 1'b0;
    in_JALR  = 1'b0;
    $display("jalr rd=%0d writeData=0x%08h", rd, writeData);
    check_value("jalr_data", writeData, 32'h44);
    tick();

    // Loads
    run_load("lb",  3'b000, 32'h0000_0103, 5'd7,  3, 32'h8012_3456, 32'hFFFF_FF80);
    run_load("lhu", 3'b101, 32'h0000_0202, 5'd8,  1, 32'hBEEF_1234, 32'h0000_BEEF);
    run_load("lh",  3'b001, 32'h0000_0202, 5'd9,  1, 32'hBEEF_1234, 32'hFFFF_BEEF);
    run_load("lw",  3'b010, 32'h0000_0300, 5'd10, 0, 32'h1234_5678, 32'h1234_5678);
    run_load("lbu", 3'b100, 32'h0000_0301, 5'd11, 2, 32'h8012_3456, 32'h0000_0034);
    run_load("lh0", 3'b001, 32'h0000_0300, 5'd12, 0, 32'h1234_8765, 32'hFFFF_8765);

    // Faults: LW misaligned, then back-to-back illegal funct3
    drive_op(5'd13, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0001, 32'h0);
    tick();
    $display("fault lw_mis load_fault=%0b retire=%0b write=%0b ready=%0b", load_fault, retire, write, in_ready);
    check_value("lwmis_fault", {31'b0, load_fault}, 32'd1);
    check_value("lwmis_retire", {31'b0, retire}, 32'd1);
    check_value("lwmis_write", {31'b0, write}, 32'd0);
    check_value("lwmis_ready", {31'b0, in_ready}, 32'd1);
    drive_op(5'd14, 1'b1, 1'b1, 1'b0, 3'b111, 32'h0000_0000, 32'h0);
    tick();
    in_valid = 1'b0;
    $display("fault f3_111 load_fault=%0b retire=%0b write=%0b ready=%0b", load_fault, retire, write, in_ready);
    check_value("f3ill_fault", {31'b0, load_fault}, 32'd1);
    check_value("f3ill_retire", {31'b0, retire}, 32'd1);
    check_value("f3ill_write", {31'b0, write}, 32'd0);
    check_value("f3ill_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check_value("fault_clear", {31'b0, load_fault}, 32'd0);

    // LH misaligned also faults
    drive_op(5'd15, 1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0);
    tick();
    in_valid = 1'b0;
    $display("fault lh_mis load_fault=%0b", load_fault);
    check_value("lhmis_fault", {31'b0, load_fault}, 32'd1);
    tick();

    // Write to x0 is suppressed but still retires
    drive_op(5'd0, 1'b1, 1'b0, 1'b0, 3'b000, 32'hCAFE_0000, 32'h0);
    tick();
    in_valid = 1'b0;
    $display("x0 write=%0b retire=%0b", write, retire);
    check_value("x0_write", {31'b0, write}, 32'd0);
    check_value("x0_retire", {31'b0, retire}, 32'd1);
    tick();

    // Reset during WAIT_LOAD drops the pending load
    drive_op(5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0);
    tick();
    in_valid = 1'b0;
    check_value("rml_wait_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    #2;
    check_value("rml_async_ready", {31'b0, in_ready}, 32'd1);
    tick();
    reset = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    $display("reset mid-load: write=%0b retire=%0b ready=%0b", write, retire, in_ready);
    check_value("rml_write", {31'b0, write}, 32'd0);
    check_value("rml_retire", {31'b0, retire}, 32'd0);
    check_value("rml_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check_value("rml_write_later", {31'b0, write}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage. It accepts one retiring instruction per handshake and selects the result: the ALU result, the load data, or PC+4 for JAL/JALR. For loads it waits on the data-memory response and sign/zero-extends the data using funct3. It then drives the RegisterFile write port (write/rd/writeData), which the decode stage reads.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  upstream holds a retiring instruction
in_ready  out  1  stage can accept this cycle
in_rd  in  REG_ADDR_W  destination register
in_regWrite  in  1  instruction writes rd
in_load  in  1  instruction is a load
in_JAL  in  1  JAL
in_JALR  in  1  JALR
in_funct3  in  3  load width/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
in_aluResult  in  XLEN  ALU result / load address
in_incrementedPC  in  XLEN  PC+4
mem_rvalid  in  1  load data valid
mem_rdata  in  XLEN  aligned memory word
write  out  1  RegisterFile write enable
rd  out  REG_ADDR_W  RegisterFile write index
writeData  out  XLEN  RegisterFile write data
retire  out  1  one-cycle pulse per completed instruction
load_fault  out  1  one-cycle pulse: misaligned load or illegal funct3

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; write=0, rd=0, writeData=0, retire=0, load_fault=0. in_ready=1 after reset is released. Reset during WAIT_LOAD drops the pending load with no write.
- States are IDLE, WAIT_LOAD and DONE. in_ready = (state != WAIT_LOAD). An instruction is accepted when in_valid && in_ready.
- Accepting a non-load in cycle N: in cycle N+1, write = in_regWrite && (in_rd != 0), rd = in_rd, retire=1, and state=DONE.
  - writeData = in_incrementedPC if JAL or JALR; otherwise writeData = in_aluResult.
- Accepting a load in cycle N: state=WAIT_LOAD. The stage latches rd, regWrite, funct3 and offset = in_aluResult[1:0].
- The stage holds in WAIT_LOAD until mem_rvalid=1; there is no timeout.
- mem_rvalid in cycle M: write/retire are asserted in cycle M+1, with writeData the extracted value and state=DONE.
  - mem_rvalid in the same cycle as acceptance is ignored; the response must come at least one cycle after acceptance.
- Load extraction:
  - byte = mem_rdata[8*offset +: 8]; half = mem_rdata[16*offset[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
- Load faults:
  - Misalignment is LH/LHU with offset[0]=1, or LW with offset!=0.
  - Illegal funct3 is 011, 110 or 111.
  - Either case is checked at acceptance. The stage goes to DONE with load_fault=1, write=0, retire=1, and issues no memory wait.
- rd==0: writes are always suppressed (write=0), but retire is still pulsed.
- DONE holds write/retire for exactly one cycle.
  - If a new instruction is accepted in DONE, it is processed as from IDLE, giving back-to-back throughput of 1 per cycle for non-loads.
  - Otherwise DONE returns to IDLE.
  - IDLE and DONE otherwise drive write=0, retire=0, load_fault=0. rd and writeData hold their last values.
- mem_rvalid outside WAIT_LOAD is ignored.
- All outputs are registered. No combinational path runs from in_* to write/rd/writeData.

Decomposition:
- Shared package riscv_pkg:
  - funct3 load-code constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - wb_state enum: IDLE, WAIT_LOAD, DONE.
  - XLEN and REG_ADDR_W constants.
- One natural sub-module, load_extract (combinational): inputs mem_rdata, funct3, offset; outputs value, fault.

Test Plan:
- Reset: hold reset=0 and drive in_valid=1 -> write=0, retire=0, in_ready ignored. Release reset -> in_ready=1; nothing is written until a new accept.
- ALU op then JAL: accept rd=5, aluResult=0x0000_0010, then back-to-back rd=1, JAL=1, incrementedPC=0x0000_0008.
  - Response: write=1 rd=5 data=0x10 in cycle N+1, then write=1 rd=1 data=0x8 in N+2, with two retire pulses.
- LB sign-extend: accept load funct3=000, aluResult=0x...03; wait 3 cycles; mem_rvalid=1, mem_rdata=0x80_12_34_56.
  - Response: in_ready=0 during the wait; one cycle later write=1, writeData=0xFFFF_FF80.
- LHU zero-extend: aluResult offset=2, mem_rdata=0xBEEF_1234 -> writeData=0x0000_BEEF. The LH variant gives 0xFFFF_BEEF.
- Faults: LW at offset 1, and funct3=111.
  - Response: load_fault=1 and retire=1 next cycle, write=0, no wait (in_ready stays 1).
- Write to x0 and reset mid-load:
  - ALU op with rd=0 -> retire=1, write=0.
  - Accept a load, assert reset=0 before mem_rvalid, release, then pulse mem_rvalid -> no write, state IDLE.
